// File: rtl/execute_stage_pkg.sv
// Shared encodings and types for the execute stage: ALU op codes, forward selects,
// multiplier iteration count and the multiplier FSM state type.
package execute_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int MUL_CYCLES = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  // Select 11 is unused by the hazard unit and falls back to the register file value.
  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] reg_val,
    input logic [DATA_W-1:0] wb_val,
    input logic [DATA_W-1:0] mem_val
  );
    logic [DATA_W-1:0] res;
    case (sel)
      FWD_WB:  res = wb_val;
      FWD_MEM: res = mem_val;
      default: res = reg_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/execute_stage_mul.sv
// Iterative shift-add multiplier producing the low 32 bits of a*b after MUL_CYCLES steps.
// Operands are captured on start so later changes on a/b do not disturb the result.
module mul_iter
  import execute_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(MUL_CYCLES);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] prod_q, prod_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d  = MUL_BUSY;
          count_d  = '0;
          mcand_d  = a;
          mplier_d = b;
          prod_d   = '0;
        end
      end
      MUL_BUSY: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = {mcand_q[DATA_W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
        count_d  = count_q + 1'b1;
        if (count_q == CNT_W'(MUL_CYCLES - 1)) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        state_d = MUL_IDLE;
      end
      default: begin
        state_d = MUL_IDLE;
      end
    endcase
    // Abort wins over everything, including a start in the same cycle.
    if (abort) begin
      state_d  = MUL_IDLE;
      count_d  = '0;
      mcand_d  = '0;
      mplier_d = '0;
      prod_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MUL_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign busy    = (state_q == MUL_BUSY);
  assign done    = (state_q == MUL_DONE);
  assign product = prod_q;

endmodule

// File: rtl/execute_stage.sv
// Pipeline EX stage: operand forwarding, single-cycle ALU, multi-cycle MUL with stall,
// and the EX/MEM pipeline register (bubbles on stall or flush).
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_wr_en,
  input  logic             mem_wr_en,
  input  logic             mem_to_reg_wr,
  input  logic             alu_src,
  input  logic             reg_dst,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] sign_imm,
  input  logic [4:0]       rt_addr,
  input  logic [4:0]       rd_addr,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic [WIDTH-1:0] mem_fwd_data,
  input  logic [WIDTH-1:0] wb_fwd_data,
  input  logic             flush,
  output logic             ex_mem_reg_wr_en,
  output logic             ex_mem_mem_wr_en,
  output logic             ex_mem_mem_to_reg_wr,
  output logic [4:0]       ex_mem_reg_wr_addr,
  output logic [WIDTH-1:0] ex_mem_alu_result,
  output logic [WIDTH-1:0] ex_mem_mem_wr_data,
  output logic [4:0]       ex_reg_wr_addr,
  output logic             ex_stall
);

  logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_out;
  logic             mul_issue, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;

  logic             reg_wr_en_q, reg_wr_en_d;
  logic             mem_wr_en_q, mem_wr_en_d;
  logic             mem_to_reg_wr_q, mem_to_reg_wr_d;
  logic [4:0]       reg_wr_addr_q, reg_wr_addr_d;
  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;

  assign src_a          = fwd_mux(fwd_a_sel, rd1, wb_fwd_data, mem_fwd_data);
  assign fwd_b          = fwd_mux(fwd_b_sel, rd2, wb_fwd_data, mem_fwd_data);
  assign src_b          = alu_src ? sign_imm : fwd_b;
  assign ex_reg_wr_addr = reg_dst ? rd_addr : rt_addr;

  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      ALU_AND: alu_out = src_a & src_b;
      ALU_OR:  alu_out = src_a | src_b;
      ALU_ADD: alu_out = src_a + src_b;
      ALU_XOR: alu_out = src_a ^ src_b;
      ALU_SUB: alu_out = src_a - src_b;
      ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_NOR: alu_out = ~(src_a | src_b);
      default: alu_out = '0;
    endcase
  end

  // The DONE cycle still presents the finished MUL, so it must not re-issue it.
  assign mul_issue = (alu_ctrl == ALU_MUL) && !flush && !mul_busy && !mul_done;
  assign ex_stall  = mul_issue || mul_busy;

  mul_iter u_mul_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_issue),
    .abort   (flush),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    reg_wr_en_d     = 1'b0;
    mem_wr_en_d     = 1'b0;
    mem_to_reg_wr_d = 1'b0;
    reg_wr_addr_d   = '0;
    alu_result_d    = '0;
    mem_wr_data_d   = '0;
    if (!flush && !ex_stall) begin
      reg_wr_en_d     = reg_wr_en;
      mem_wr_en_d     = mem_wr_en;
      mem_to_reg_wr_d = mem_to_reg_wr;
      reg_wr_addr_d   = ex_reg_wr_addr;
      alu_result_d    = mul_done ? mul_product : alu_out;
      mem_wr_data_d   = fwd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_wr_en_q     <= 1'b0;
      mem_wr_en_q     <= 1'b0;
      mem_to_reg_wr_q <= 1'b0;
      reg_wr_addr_q   <= '0;
      alu_result_q    <= '0;
      mem_wr_data_q   <= '0;
    end else begin
      reg_wr_en_q     <= reg_wr_en_d;
      mem_wr_en_q     <= mem_wr_en_d;
      mem_to_reg_wr_q <= mem_to_reg_wr_d;
      reg_wr_addr_q   <= reg_wr_addr_d;
      alu_result_q    <= alu_result_d;
      mem_wr_data_q   <= mem_wr_data_d;
    end
  end

  assign ex_mem_reg_wr_en     = reg_wr_en_q;
  assign ex_mem_mem_wr_en     = mem_wr_en_q;
  assign ex_mem_mem_to_reg_wr = mem_to_reg_wr_q;
  assign ex_mem_reg_wr_addr   = reg_wr_addr_q;
  assign ex_mem_alu_result    = alu_result_q;
  assign ex_mem_mem_wr_data   = mem_wr_data_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus random single-cycle ops,
// compared against a behavioural model built from plain arithmetic.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_wr_en, mem_wr_en, mem_to_reg_wr, alu_src, reg_dst;
  logic [3:0]  alu_ctrl;
  logic [31:0] rd1, rd2, sign_imm;
  logic [4:0]  rt_addr, rd_addr;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        flush;
  logic        ex_mem_reg_wr_en, ex_mem_mem_wr_en, ex_mem_mem_to_reg_wr;
  logic [4:0]  ex_mem_reg_wr_addr;
  logic [31:0] ex_mem_alu_result, ex_mem_mem_wr_data;
  logic [4:0]  ex_reg_wr_addr;
  logic        ex_stall;

  int errors = 0;
  int checks = 0;

  logic [3:0] op_table [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
                                4'b0111, 4'b1100, 4'b0100, 4'b0101, 4'b1111};

  execute_stage #(.WIDTH(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .reg_wr_en            (reg_wr_en),
    .mem_wr_en            (mem_wr_en),
    .mem_to_reg_wr        (mem_to_reg_wr),
    .alu_src              (alu_src),
    .reg_dst              (reg_dst),
    .alu_ctrl             (alu_ctrl),
    .rd1                  (rd1),
    .rd2                  (rd2),
    .sign_imm             (sign_imm),
    .rt_addr              (rt_addr),
    .rd_addr              (rd_addr),
    .fwd_a_sel            (fwd_a_sel),
    .fwd_b_sel            (fwd_b_sel),
    .mem_fwd_data         (mem_fwd_data),
    .wb_fwd_data          (wb_fwd_data),
    .flush                (flush),
    .ex_mem_reg_wr_en     (ex_mem_reg_wr_en),
    .ex_mem_mem_wr_en     (ex_mem_mem_wr_en),
    .ex_mem_mem_to_reg_wr (ex_mem_mem_to_reg_wr),
    .ex_mem_reg_wr_addr   (ex_mem_reg_wr_addr),
    .ex_mem_alu_result    (ex_mem_alu_result),
    .ex_mem_mem_wr_data   (ex_mem_mem_wr_data),
    .ex_reg_wr_addr       (ex_reg_wr_addr),
    .ex_stall             (ex_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] r,
                                            input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return r;
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: return ~(a | b);
      4'd8:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s failed", tag);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic src, input logic dst,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic [31:0] wb, input logic [31:0] mem,
                               input logic rw, input logic mw, input logic m2r, input logic fl);
    alu_ctrl = op;  rd1 = a;  rd2 = b;  sign_imm = imm;  alu_src = src;  reg_dst = dst;
    rt_addr = rt;  rd_addr = rd;  fwd_a_sel = fa;  fwd_b_sel = fb;
    wb_fwd_data = wb;  mem_fwd_data = mem;
    reg_wr_en = rw;  mem_wr_en = mw;  mem_to_reg_wr = m2r;  flush = fl;
    #1;
  endtask

  task automatic checkBubble(input string tag);
    checkOutput({tag, "_regwr"}, 32'(ex_mem_reg_wr_en), 32'd0);
    checkOutput({tag, "_memwr"}, 32'(ex_mem_mem_wr_en), 32'd0);
    checkOutput({tag, "_m2r"},   32'(ex_mem_mem_to_reg_wr), 32'd0);
    checkOutput({tag, "_addr"},  32'(ex_mem_reg_wr_addr), 32'd0);
    checkOutput({tag, "_res"},   ex_mem_alu_result, 32'd0);
    checkOutput({tag, "_wdata"}, ex_mem_mem_wr_data, 32'd0);
  endtask

  // Caller has already driven a MUL; follows it to completion within a bounded cycle budget.
  task automatic runMul(input string tag, input logic [31:0] exp_prod, input logic [4:0] exp_addr,
                        input bit scramble_mem);
    int  stall_cycles = 0;
    bit  finished     = 0;
    for (int c = 0; c < 60 && !finished; c++) begin
      if (ex_stall) begin
        stall_cycles++;
        tick();
        if (scramble_mem) mem_fwd_data = $urandom;
        #1;
        checkOutput({tag, "_bubble_regwr"}, 32'(ex_mem_reg_wr_en), 32'd0);
        checkOutput({tag, "_bubble_res"}, ex_mem_alu_result, 32'd0);
      end else begin
        tick();
        checkOutput({tag, "_result"}, ex_mem_alu_result, exp_prod);
        checkOutput({tag, "_regwr"}, 32'(ex_mem_reg_wr_en), 32'd1);
        checkOutput({tag, "_addr"}, 32'(ex_mem_reg_wr_addr), 32'(exp_addr));
        finished = 1;
      end
    end
    checkOutput({tag, "_stall_cycles"}, 32'(stall_cycles), 32'd33);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b, imm, wb, mem, exp_a, exp_b, exp_src_b, exp_res;
    logic [4:0]  rt, rd, exp_addr;
    logic [1:0]  fa, fb;
    logic        src, dst, rw, mw, m2r, fl;

    // Reset with a live instruction present: outputs must still clear.
    reset = 1'b1;
    applyStimulus(4'd2, 32'd9, 32'd9, 32'd0, 0, 1, 5'd1, 5'd2, 0, 0, 0, 0, 1, 1, 1, 0);
    tick();
    tick();
    checkBubble("reset");
    checkOutput("reset_stall", 32'(ex_stall), 32'd0);
    reset = 1'b0;

    // ADD 5+7 into r3.
    applyStimulus(4'd2, 32'd5, 32'd7, 32'd0, 0, 1, 5'd8, 5'd3, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("add_stall", 32'(ex_stall), 32'd0);
    checkOutput("add_ex_addr", 32'(ex_reg_wr_addr), 32'd3);
    tick();
    checkOutput("add_result", ex_mem_alu_result, 32'd12);
    checkOutput("add_addr", 32'(ex_mem_reg_wr_addr), 32'd3);
    checkOutput("add_regwr", 32'(ex_mem_reg_wr_en), 32'd1);

    // SUB with A forwarded from MEM.
    applyStimulus(4'd6, 32'd55, 32'd1, 32'd0, 0, 0, 5'd4, 5'd5, 2, 0, 0, 32'd100, 1, 0, 0, 0);
    tick();
    checkOutput("sub_fwd_mem", ex_mem_alu_result, 32'd99);
    checkOutput("sub_rt_addr", 32'(ex_mem_reg_wr_addr), 32'd4);

    // Signed SLT: -1 < 1.
    applyStimulus(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 5'd6, 5'd7, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    checkOutput("slt_signed", ex_mem_alu_result, 32'd1);

    // Select 11 behaves as register value; store data follows forwarded B, not the immediate.
    applyStimulus(4'd2, 32'd10, 32'd20, 32'd3, 1, 0, 5'd9, 5'd0, 3, 1, 32'd77, 32'd88, 0, 1, 0, 0);
    tick();
    checkOutput("fwd11_imm_result", ex_mem_alu_result, 32'd13);
    checkOutput("store_data_fwd_wb", ex_mem_mem_wr_data, 32'd77);
    checkOutput("store_memwr", 32'(ex_mem_mem_wr_en), 32'd1);

    // Random single-cycle ops, occasionally flushed.
    for (int i = 0; i < 60; i++) begin
      op  = op_table[$urandom_range(0, 9)];
      a   = $urandom;  b = $urandom;  imm = $urandom;  wb = $urandom;  mem = $urandom;
      if (i % 4 == 0) b = a;
      src = 1'($urandom_range(0, 1));  dst = 1'($urandom_range(0, 1));
      rt  = 5'($urandom_range(0, 31));  rd = 5'($urandom_range(0, 31));
      fa  = 2'($urandom_range(0, 3));   fb = 2'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));   mw = 1'($urandom_range(0, 1));
      m2r = 1'($urandom_range(0, 1));   fl = ($urandom_range(0, 7) == 0);
      applyStimulus(op, a, b, imm, src, dst, rt, rd, fa, fb, wb, mem, rw, mw, m2r, fl);
      exp_a     = model_fwd(fa, a, wb, mem);
      exp_b     = model_fwd(fb, b, wb, mem);
      exp_src_b = src ? imm : exp_b;
      exp_res   = model_alu(op, exp_a, exp_src_b);
      exp_addr  = dst ? rd : rt;
      checkOutput("rand_stall", 32'(ex_stall), 32'd0);
      checkOutput("rand_ex_addr", 32'(ex_reg_wr_addr), 32'(exp_addr));
      tick();
      if (fl) begin
        checkBubble("rand_flush");
      end else begin
        checkOutput("rand_result", ex_mem_alu_result, exp_res);
        checkOutput("rand_addr", 32'(ex_mem_reg_wr_addr), 32'(exp_addr));
        checkOutput("rand_wdata", ex_mem_mem_wr_data, exp_b);
        checkOutput("rand_ctrl", 32'({ex_mem_reg_wr_en, ex_mem_mem_wr_en, ex_mem_mem_to_reg_wr}),
                    32'({rw, mw, m2r}));
      end
    end

    // MUL with A forwarded from MEM; forward data is scrambled while busy.
    applyStimulus(4'd8, 32'd0, 32'h0001_0001, 32'd0, 0, 1, 5'd0, 5'd9, 2, 0, 0, 32'h0001_0000,
                  1, 0, 0, 0);
    checkOutput("mul_issue_stall", 32'(ex_stall), 32'd1);
    runMul("mul_big", model_alu(4'd8, 32'h0001_0000, 32'h0001_0001), 5'd9, 1);

    // Back-to-back MULs: second one issues in the cycle after DONE.
    applyStimulus(4'd8, 32'd3, 32'd4, 32'd0, 0, 1, 5'd0, 5'd10, 0, 0, 0, 0, 1, 0, 0, 0);
    runMul("mul_3x4", 32'd12, 5'd10, 0);
    applyStimulus(4'd8, 32'd5, 32'd6, 32'd0, 0, 1, 5'd0, 5'd11, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("mul_b2b_issue_stall", 32'(ex_stall), 32'd1);
    runMul("mul_5x6", 32'd30, 5'd11, 0);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("mul_regwr_one_cycle", 32'(ex_mem_reg_wr_en), 32'd0);

    // Flush in the tenth BUSY cycle.
    applyStimulus(4'd8, 32'd7, 32'd9, 32'd0, 0, 1, 5'd0, 5'd12, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    repeat (9) tick();
    checkOutput("flush_pre_stall", 32'(ex_stall), 32'd1);
    flush = 1'b1;
    #1;
    tick();
    checkBubble("flush_bubble");
    applyStimulus(4'd2, 32'd2, 32'd3, 32'd0, 0, 1, 5'd0, 5'd13, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("flush_stall_released", 32'(ex_stall), 32'd0);
    for (int c = 0; c < 40; c++) begin
      tick();
      checkOutput("flush_no_mul_result", ex_mem_alu_result, 32'd5);
      checkOutput("flush_no_stall", 32'(ex_stall), 32'd0);
    end

    // Reset in the middle of a MUL, then ADD 1+1.
    applyStimulus(4'd8, 32'd11, 32'd13, 32'd0, 0, 1, 5'd0, 5'd14, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (5) tick();
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'd2, 32'd1, 32'd1, 32'd0, 0, 1, 5'd0, 5'd15, 0, 0, 0, 0, 1, 0, 0, 0);
    checkBubble("midmul_reset");
    checkOutput("midmul_reset_stall", 32'(ex_stall), 32'd0);
    tick();
    checkOutput("post_reset_add", ex_mem_alu_result, 32'd2);
    checkOutput("post_reset_regwr", 32'(ex_mem_reg_wr_en), 32'd1);
    checkOutput("post_reset_addr", 32'(ex_mem_reg_wr_addr), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
